tpu_host_bridge: RTL

- Parametrised byte-stream command engine between a byte transport (UART RX/TX byte ports) and an N-column MLP core.
- Next-generation replacement for the fixed 2-column controller/bridge pair.
- Generalised in column count, accumulator width and config space.
- Adds length-prefixed weight bursts, an accumulator snapshot readback, a generic config bus, inter-byte timeout and sticky error reporting.

---
 rtl/tpu_host_bridge.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tpu_host_bridge.sv
// Byte-stream command engine bridging a UART byte transport to an N-column MLP core; optional write acks via TPU_HOST_ACK_EN.
// Latency: strobes one cycle after the completing rx byte; responses start the cycle after decode.
// Backpressure: tx holds tx_valid/tx_data until tx_ready; rx cannot be stalled, so bytes arriving during a response are dropped and flagged.
module tpu_host_bridge #(
    parameter int NUM_COLS       = 2,
    parameter int ACC_W          = 32,
    parameter int CFG_ADDR_W     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    input  logic                      tx_ready,
    output logic [NUM_COLS-1:0]       wf_push,
    output logic [7:0]                wf_data,
    output logic                      wf_reset,
    output logic                      init_act_valid,
    output logic [8*NUM_COLS-1:0]     init_act_data,
    output logic                      start_mlp,
    output logic                      weights_ready,
    output logic                      cfg_we,
    output logic [CFG_ADDR_W-1:0]     cfg_addr,
    output logic [31:0]               cfg_data,
    input  logic [3:0]                mlp_state,
    input  logic [NUM_COLS*ACC_W-1:0] mlp_acc,
    output logic                      busy,
    output logic [1:0]                err
);

    localparam int SNAP_W     = NUM_COLS * ACC_W;
    localparam int RESP_BYTES = SNAP_W / 8;
    localparam int CNT_MAX    = (RESP_BYTES > 256) ? RESP_BYTES : 256;
    localparam int CNT_W      = $clog2(CNT_MAX) + 1;
    localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam int TMO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_LAST_I[TMO_W-1:0];
    localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] RESP_CNT = RESP_BYTES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(NUM_COLS - 1);
    localparam logic [4:0]       NC5      = NUM_COLS[4:0];

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] GET_LEN  = 3'd1;
    localparam logic [2:0] WEIGHTS  = 3'd2;
    localparam logic [2:0] ACT      = 3'd3;
    localparam logic [2:0] CFG_ADDR = 3'd4;
    localparam logic [2:0] CFG_DATA = 3'd5;
    localparam logic [2:0] RESP     = 3'd6;

`ifdef TPU_HOST_ACK_EN
    localparam logic       ACK_EN  = 1'b1;
    localparam logic [2:0] WR_NEXT = RESP;
`else
    localparam logic       ACK_EN  = 1'b0;
    localparam logic [2:0] WR_NEXT = IDLE;
`endif

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        col;
    logic [SNAP_W-1:0] snap;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              ack_pend;
    logic              in_cmd;
    logic              tmo_hit;

    assign busy    = (state != IDLE);
    assign in_cmd  = (state != IDLE) && (state != RESP);
    assign tmo_hit = TMO_EN && in_cmd && !rx_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            col            <= '0;
            snap           <= '0;
            tmo_cnt        <= '0;
            ack_pend       <= 1'b0;
            tx_valid       <= 1'b0;
            tx_data        <= '0;
            wf_push        <= '0;
            wf_data        <= '0;
            wf_reset       <= 1'b0;
            init_act_valid <= 1'b0;
            init_act_data  <= '0;
            start_mlp      <= 1'b0;
            weights_ready  <= 1'b0;
            cfg_we         <= 1'b0;
            cfg_addr       <= '0;
            cfg_data       <= '0;
            err            <= '0;
        end else begin
            wf_push        <= '0;
            wf_reset       <= 1'b0;
            init_act_valid <= 1'b0;
            start_mlp      <= 1'b0;
            cfg_we         <= 1'b0;

            if (!in_cmd || rx_valid) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (tmo_hit) begin
                state  <= IDLE;
                err[0] <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_valid) begin
                            if (rx_data[7:4] == 4'h1 && {1'b0, rx_data[3:0]} < NC5) begin
                                col   <= rx_data[2:0];
                                state <= GET_LEN;
                            end else begin
                                case (rx_data)
                                    8'h20: begin
                                        wf_reset      <= 1'b1;
                                        weights_ready <= 1'b0;
                                        cnt           <= CNT_W'(1);
                                        ack_pend      <= ACK_EN;
                                        state         <= WR_NEXT;
                                    end
                                    8'h30: begin
                                        cnt   <= '0;
                                        state <= ACT;
                                    end
                                    8'h40: state <= CFG_ADDR;
                                    8'h50: begin
                                        weights_ready <= 1'b1;
                                        start_mlp     <= 1'b1;
                                        cnt           <= CNT_W'(1);
                                        ack_pend      <= ACK_EN;
                                        state         <= WR_NEXT;
                                    end
                                    8'h60: begin
                                        tx_valid <= 1'b1;
                                        tx_data  <= {4'h0, mlp_state};
                                        cnt      <= CNT_W'(1);
                                        state    <= RESP;
                                    end
                                    8'h70: begin
                                        // Snapshot is shifted out byte by byte so the core may keep updating.
                                        tx_valid <= 1'b1;
                                        tx_data  <= mlp_acc[7:0];
                                        snap     <= mlp_acc >> 8;
                                        cnt      <= RESP_CNT;
                                        state    <= RESP;
                                    end
                                    8'h7f: begin
                                        tx_valid <= 1'b1;
                                        tx_data  <= {6'h0, err};
                                        err      <= '0;
                                        cnt      <= CNT_W'(1);
                                        state    <= RESP;
                                    end
                                    default: begin
                                        tx_valid <= 1'b1;
                                        tx_data  <= 8'hEE;
                                        err[0]   <= 1'b1;
                                        cnt      <= CNT_W'(1);
                                        state    <= RESP;
                                    end
                                endcase
                            end
                        end
                    end
                    GET_LEN: begin
                        if (rx_valid) begin
                            cnt   <= (rx_data == 8'h00) ? CNT_W'(256) : CNT_W'(rx_data);
                            state <= WEIGHTS;
                        end
                    end
                    WEIGHTS: begin
                        if (rx_valid) begin
                            for (int i = 0; i < NUM_COLS; i++) begin
                                wf_push[i] <= (col == i[2:0]);
                            end
                            wf_data <= rx_data;
                            if (cnt == CNT_W'(1)) begin
                                ack_pend <= ACK_EN;
                                state    <= WR_NEXT;
                            end else begin
                                cnt <= cnt - 1'b1;
                            end
                        end
                    end
                    ACT: begin
                        if (rx_valid) begin
                            for (int i = 0; i < NUM_COLS; i++) begin
                                if (cnt == CNT_W'(i)) begin
                                    init_act_data[8*i +: 8] <= rx_data;
                                end
                            end
                            if (cnt == ACT_LAST) begin
                                init_act_valid <= 1'b1;
                                cnt            <= CNT_W'(1);
                                ack_pend       <= ACK_EN;
                                state          <= WR_NEXT;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    CFG_ADDR: begin
                        if (rx_valid) begin
                            cfg_addr <= rx_data[CFG_ADDR_W-1:0];
                            cnt      <= '0;
                            state    <= CFG_DATA;
                        end
                    end
                    CFG_DATA: begin
                        if (rx_valid) begin
                            for (int i = 0; i < 4; i++) begin
                                if (cnt == CNT_W'(i)) begin
                                    cfg_data[8*i +: 8] <= rx_data;
                                end
                            end
                            if (cnt == CNT_W'(3)) begin
                                cfg_we   <= 1'b1;
                                cnt      <= CNT_W'(1);
                                ack_pend <= ACK_EN;
                                state    <= WR_NEXT;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    RESP: begin
                        if (rx_valid) begin
                            err[1] <= 1'b1;
                        end
                        // cnt counts bytes still to transfer, including the one on tx_data.
                        if (ack_pend) begin
                            ack_pend <= 1'b0;
                            tx_valid <= 1'b1;
                            tx_data  <= 8'hAC;
                        end else if (tx_valid && tx_ready) begin
                            if (cnt == CNT_W'(1)) begin
                                tx_valid <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                cnt     <= cnt - 1'b1;
                                tx_data <= snap[7:0];
                                snap    <= snap >> 8;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
